// File: rtl/cp0_if.sv
// CP0 pipeline-facing bus: MEM-stage instruction info, interrupt lines,
// mtc0/mfc0/eret access and the exception request back to the pipeline.
interface cp0_if;
   logic [31:0] pc_M;
   logic [4:0]  ExcCode_M;
   logic [5:0]  HWInt;
   logic        we_M;
   logic        eret_M;
   logic [4:0]  addr;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic [31:0] EPC;
   logic        IntReq;

   // pipeline side
   modport master (
      output pc_M, ExcCode_M, HWInt, we_M, eret_M, addr, DIn,
      input  DOut, EPC, IntReq
   );

   // coprocessor side
   modport slave (
      input  pc_M, ExcCode_M, HWInt, we_M, eret_M, addr, DIn,
      output DOut, EPC, IntReq
   );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: exception/interrupt decision at the MEM stage plus the
// SR / Cause / EPC / PRId register file used by mtc0, mfc0 and eret.
module cp0 #(
   parameter logic [31:0] PRID     = 32'h4D49_5053,
   parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
   input  logic  clk,
   input  logic  reset,
   cp0_if.slave  bus
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:2] epc_q;

   logic        irq;
   logic        exc;
   logic        take;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] epc_word;

   // Decision uses only live state and MEM-stage exception inputs; we_M,
   // DIn and eret_M stay out of this path to avoid a forwarding loop.
   assign irq  = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
   assign exc  = (bus.ExcCode_M != 5'd0) & ~sr_exl;
   assign take = irq | exc;

   assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
   assign cause_word = {16'd0, cause_ip, 3'd0, cause_exc, 2'd0};
   assign epc_word   = {epc_q, 2'b00};

   assign bus.IntReq = take;
   assign bus.EPC    = epc_word;

   // mfc0 read mux; no bypass of same-cycle writes
   always_comb begin
      bus.DOut = 32'd0;
      case (bus.addr)
         5'd12:   bus.DOut = sr_word;
         5'd13:   bus.DOut = cause_word;
         5'd14:   bus.DOut = epc_word;
         5'd15:   bus.DOut = PRID;
         default: bus.DOut = 32'd0;
      endcase
   end

   // Register update: reset, then exception entry (victim's mtc0/eret
   // suppressed), otherwise mtc0 and eret; eret is last so it wins on EXL.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= SR_RESET[15:10];
         sr_exl    <= SR_RESET[1];
         sr_ie     <= SR_RESET[0];
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc_q     <= 30'd0;
      end else begin
         cause_ip <= bus.HWInt;
         if (take) begin
            sr_exl    <= 1'b1;
            cause_exc <= irq ? 5'd0 : bus.ExcCode_M;
            epc_q     <= bus.pc_M[31:2];
         end else begin
            if (bus.we_M && bus.addr == 5'd12) begin
               sr_im  <= bus.DIn[15:10];
               sr_exl <= bus.DIn[1];
               sr_ie  <= bus.DIn[0];
            end
            if (bus.we_M && bus.addr == 5'd14)
               epc_q <= bus.DIn[31:2];
            if (bus.eret_M)
               sr_exl <= 1'b0;
         end
      end
   end

   // pc_M low bits are discarded because EPC is word-aligned
   logic unused_pc_lo;
   assign unused_pc_lo = ^bus.pc_M[1:0];

endmodule

// File: tb/tb_cp0.sv
// Randomized bench for cp0 against a word-level register model, preceded
// by directed scenarios with hand-derived expected values.
module tb_cp0;
   localparam logic [31:0] PRID    = 32'h4D49_5053;
   localparam logic [31:0] SR_MASK = 32'h0000_FC03;

   logic clk = 1'b0;
   logic reset;
   cp0_if bus();

   cp0 #(.PRID(PRID), .SR_RESET(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // model state as whole architectural words
   logic [31:0] m_sr, m_cause, m_epc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   function automatic bit m_irq();
      return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_exc();
      return (bus.ExcCode_M != 5'd0) && !m_sr[1];
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   // Apply inputs mid-cycle and check combinational outputs against the model
   task automatic drive(input logic rst, input logic [31:0] pc, input logic [4:0] ec,
                        input logic [5:0] hw, input logic we, input logic er,
                        input logic [4:0] ad, input logic [31:0] din);
      @(negedge clk);
      reset = rst; bus.pc_M = pc; bus.ExcCode_M = ec; bus.HWInt = hw;
      bus.we_M = we; bus.eret_M = er; bus.addr = ad; bus.DIn = din;
      #1;
      chk("IntReq", {31'd0, bus.IntReq}, {31'd0, m_irq() | m_exc()});
      chk("DOut",   bus.DOut, m_read(ad));
      chk("EPC",    bus.EPC,  m_epc);
   endtask

   // Clock edge: advance the model with the inputs held at that edge
   task automatic edge_upd();
      bit irq, take;
      @(posedge clk);
      irq  = m_irq();
      take = irq | m_exc();
      if (reset) begin
         m_sr = 32'h0000_0000 & SR_MASK; m_cause = 0; m_epc = 0;
      end else begin
         if (take) begin
            m_sr    = m_sr | 32'h2;
            m_cause = irq ? 32'd0 : (32'(bus.ExcCode_M) * 4);
            m_epc   = bus.pc_M & ~32'h3;
         end else begin
            if (bus.we_M && bus.addr == 5'd12) m_sr  = bus.DIn & SR_MASK;
            if (bus.we_M && bus.addr == 5'd14) m_epc = bus.DIn & ~32'h3;
            if (bus.eret_M) m_sr = m_sr & ~32'h2;
         end
         m_cause = (m_cause & 32'h0000_007C) | (32'(bus.HWInt) * 1024);
      end
   endtask

   // Post-edge read of a register, checked against a fixed value
   task automatic rd(input string tag, input logic [4:0] ad, input logic [31:0] exp);
      bus.addr = ad;
      #1;
      chk(tag, bus.DOut, exp);
   endtask

   initial begin
      logic [4:0] ad;
      m_sr = 0; m_cause = 0; m_epc = 0;
      reset = 1'b1;
      bus.pc_M = 0; bus.ExcCode_M = 0; bus.HWInt = 0; bus.we_M = 0;
      bus.eret_M = 0; bus.addr = 0; bus.DIn = 0;

      // reset state
      drive(1, 0, 0, 0, 0, 0, 0, 0); edge_upd();
      drive(1, 0, 0, 0, 0, 0, 0, 0); edge_upd();
      rd("rst_sr", 12, 32'h0);
      rd("rst_cause", 13, 32'h0);
      rd("rst_epc", 14, 32'h0);
      rd("rst_prid", 15, 32'h4D49_5053);
      chk("rst_intreq", {31'd0, bus.IntReq}, 32'd0);

      // enabled interrupt
      drive(0, 0, 0, 0, 1, 0, 12, 32'h0000_0401); edge_upd();
      drive(0, 32'h0000_3008, 0, 6'b000001, 0, 0, 0, 0);
      chk("irq_take", {31'd0, bus.IntReq}, 32'd1);
      edge_upd();
      rd("irq_epc", 14, 32'h0000_3008);
      rd("irq_sr", 12, 32'h0000_0403);
      rd("irq_cause", 13, 32'h0000_0400);
      drive(0, 32'h0000_300C, 0, 6'b000001, 0, 0, 13, 0);
      chk("exl_block", {31'd0, bus.IntReq}, 32'd0);
      edge_upd();

      // exception with interrupts disabled, unaligned pc
      drive(0, 0, 0, 0, 1, 0, 12, 32'h0); edge_upd();
      drive(0, 32'h0000_300E, 5'd10, 0, 0, 0, 0, 0);
      chk("exc_take", {31'd0, bus.IntReq}, 32'd1);
      edge_upd();
      rd("exc_epc", 14, 32'h0000_300C);
      rd("exc_cause", 13, 32'h0000_0028);

      // interrupt beats exception; same-cycle mtc0 EPC suppressed
      drive(0, 0, 0, 0, 1, 0, 12, 32'h0000_0401); edge_upd();
      drive(0, 32'h0000_4000, 5'd4, 6'b000001, 1, 0, 14, 32'hFFFF_FFFF);
      chk("prio_take", {31'd0, bus.IntReq}, 32'd1);
      edge_upd();
      rd("prio_cause", 13, 32'h0000_0400);
      rd("prio_epc", 14, 32'h0000_4000);

      // eret releases EXL; pending interrupt fires next cycle
      drive(0, 32'h0000_4004, 0, 6'b000001, 0, 1, 0, 0);
      chk("eret_same", {31'd0, bus.IntReq}, 32'd0);
      edge_upd();
      drive(0, 32'h0000_5000, 0, 6'b000001, 0, 0, 0, 0);
      chk("eret_next", {31'd0, bus.IntReq}, 32'd1);
      edge_upd();

      // reset right after an exception
      drive(1, 0, 0, 0, 0, 0, 0, 0); edge_upd();
      rd("rst2_sr", 12, 32'h0);
      rd("rst2_cause", 13, 32'h0);
      rd("rst2_epc", 14, 32'h0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 5))
            0: ad = 5'd12;
            1: ad = 5'd13;
            2: ad = 5'd14;
            3: ad = 5'd15;
            default: ad = 5'($urandom);
         endcase
         drive(($urandom_range(0, 60) == 0),
               $urandom,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
               ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0),
               ad,
               ($urandom_range(0, 1) == 0) ? ($urandom | 32'h0000_0401) : $urandom);
         edge_upd();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
